// File: rtl/bcd_stopwatch_cnt_if.sv
// Control and display bundle for the MM:SS.hh stopwatch counter.
// The master side drives the controls and the slave side drives the count.
interface bcd_stopwatch_cnt_if;
    logic        ce;
    logic        up;
    logic        load;
    logic [23:0] load_val;
    logic        lap;
    logic        lap_clr;
    logic [23:0] time_bcd;
    logic [23:0] lap_bcd;
    logic        lap_valid;
    logic        at_limit;
    logic        done;

    modport master (
        output ce, up, load, load_val, lap, lap_clr,
        input  time_bcd, lap_bcd, lap_valid, at_limit, done
    );

    modport slave (
        input  ce, up, load, load_val, lap, lap_clr,
        output time_bcd, lap_bcd, lap_valid, at_limit, done
    );
endinterface

// File: rtl/bcd_stopwatch_cnt.sv
// Six-digit BCD up/down stopwatch (MM:SS.hh) with preset, saturate/wrap and done pulse.
// Lap capture is compiled in when BCD_STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_cnt #(
    parameter int MIN_MSB_MAX = 5,
    parameter int WRAP        = 0
) (
    input logic           clk_100hz,
    input logic           clr_n,
    bcd_stopwatch_cnt_if.slave bus
);

    localparam logic [3:0]  MM   = 4'(MIN_MSB_MAX);
    localparam logic [23:0] TERM = {MM, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    // Digit 0 is hundredths lsb, digit 5 is minutes msb.
    function automatic logic [3:0] dmax(input int i);
        if (i == 5)
            return MM;
        else if (i == 3)
            return 4'd5;
        else
            return 4'd9;
    endfunction

    logic [23:0] cnt_q;
    logic        done_q;
    logic [23:0] cnt_inc;
    logic [23:0] cnt_dec;
    logic [23:0] cnt_ld;
    logic [23:0] cnt_step;
    logic        inc_c;
    logic        dec_b;
    logic        at_top;
    logic        at_zero;
    logic        at_limit;
    logic        step_lim;
    logic        cnt_en;
    logic        done_d;

    always_comb begin
        inc_c   = 1'b1;
        cnt_inc = cnt_q;
        for (int i = 0; i < 6; i++) begin
            if (inc_c)
                cnt_inc[4*i +: 4] = (cnt_q[4*i +: 4] >= dmax(i)) ?
                                    4'd0 : cnt_q[4*i +: 4] + 4'd1;
            inc_c = inc_c && (cnt_q[4*i +: 4] >= dmax(i));
        end
    end

    always_comb begin
        dec_b   = 1'b1;
        cnt_dec = cnt_q;
        for (int i = 0; i < 6; i++) begin
            if (dec_b)
                cnt_dec[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd0) ?
                                    dmax(i) : cnt_q[4*i +: 4] - 4'd1;
            dec_b = dec_b && (cnt_q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        cnt_ld = '0;
        for (int i = 0; i < 6; i++) begin
            cnt_ld[4*i +: 4] = (bus.load_val[4*i +: 4] > dmax(i)) ?
                               dmax(i) : bus.load_val[4*i +: 4];
        end
    end

    // Stepping past either limit naturally lands on the opposite limit.
    always_comb begin
        at_top   = (cnt_q == TERM);
        at_zero  = (cnt_q == 24'h0);
        at_limit = bus.up ? at_top : at_zero;
        cnt_step = bus.up ? cnt_inc : cnt_dec;
        step_lim = bus.up ? (cnt_step == TERM) : (cnt_step == 24'h0);
        cnt_en   = bus.ce && !bus.load && !(at_limit && (WRAP == 0));
        done_d   = cnt_en && ((WRAP != 0) ? at_limit : step_lim);
    end

    always_ff @(posedge clk_100hz or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (bus.load)
                cnt_q <= cnt_ld;
            else if (cnt_en)
                cnt_q <= cnt_step;
        end
    end

    assign bus.time_bcd = cnt_q;
    assign bus.at_limit = at_limit;
    assign bus.done     = done_q;

`ifdef BCD_STOPWATCH_LAP_EN
    logic [23:0] lap_q;
    logic        lap_v_q;

    always_ff @(posedge clk_100hz or negedge clr_n) begin
        if (!clr_n) begin
            lap_q   <= '0;
            lap_v_q <= 1'b0;
        end else if (bus.lap_clr) begin
            lap_q   <= '0;
            lap_v_q <= 1'b0;
        end else if (bus.lap) begin
            lap_q   <= cnt_q;
            lap_v_q <= 1'b1;
        end
    end

    assign bus.lap_bcd   = lap_q;
    assign bus.lap_valid = lap_v_q;
`else
    logic unused_lap;

    assign unused_lap    = bus.lap ^ bus.lap_clr;
    assign bus.lap_bcd   = '0;
    assign bus.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_cnt.sv
// Scoreboard bench for bcd_stopwatch_cnt: one saturating and one wrapping instance.
// Stimulus queues expected results; a monitor compares them on the falling edge.
module tb_bcd_stopwatch_cnt;

`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    typedef struct {
        string       nm;
        bit          w;
        logic [23:0] t;
        logic        d;
        logic        lim;
        logic [23:0] lp;
        logic        lv;
    } exp_t;

    logic clk;
    logic clr_n;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];
    exp_t e;
    event chk_now;
    logic [50:0] act;
    logic [50:0] req;

    bcd_stopwatch_cnt_if s_if ();
    bcd_stopwatch_cnt_if w_if ();

    bcd_stopwatch_cnt #(.MIN_MSB_MAX(5), .WRAP(0)) u_sat (
        .clk_100hz (clk),
        .clr_n     (clr_n),
        .bus       (s_if)
    );

    bcd_stopwatch_cnt #(.MIN_MSB_MAX(5), .WRAP(1)) u_wrap (
        .clk_100hz (clk),
        .clr_n     (clr_n),
        .bus       (w_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] lx(input logic [23:0] v);
        return LAP ? v : 24'h0;
    endfunction

    function automatic void push(input string nm, input bit w,
                                 input logic [23:0] t, input logic d,
                                 input logic lim, input logic [23:0] lp,
                                 input logic lv);
        exp_t x;
        x.nm  = nm;
        x.w   = w;
        x.t   = t;
        x.d   = d;
        x.lim = lim;
        x.lp  = lp;
        x.lv  = lv;
        exp_q.push_back(x);
    endfunction

    always begin
        @(negedge clk or chk_now);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.w)
                act = {w_if.time_bcd, w_if.done, w_if.at_limit,
                       w_if.lap_bcd, w_if.lap_valid};
            else
                act = {s_if.time_bcd, s_if.done, s_if.at_limit,
                       s_if.lap_bcd, s_if.lap_valid};
            req = {e.t, e.d, e.lim, e.lp, e.lv};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("FAIL %s: got t=%h done=%b lim=%b lap=%h lv=%b, want t=%h done=%b lim=%b lap=%h lv=%b",
                         e.nm, act[50:27], act[26], act[25], act[24:1], act[0],
                         req[50:27], req[26], req[25], req[24:1], req[0]);
            end
        end
    end

    task automatic set_s(input logic ce, input logic up, input logic ld,
                         input logic [23:0] lv, input logic lp,
                         input logic lc);
        s_if.ce       = ce;
        s_if.up       = up;
        s_if.load     = ld;
        s_if.load_val = lv;
        s_if.lap      = lp;
        s_if.lap_clr  = lc;
    endtask

    task automatic set_w(input logic ce, input logic up, input logic ld,
                         input logic [23:0] lv);
        w_if.ce       = ce;
        w_if.up       = up;
        w_if.load     = ld;
        w_if.load_val = lv;
        w_if.lap      = 1'b0;
        w_if.lap_clr  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr_n = 1'b0;
        set_s(0, 0, 0, 24'h0, 0, 0);
        set_w(0, 0, 0, 24'h0);
        #3;
        push("rst_s", 0, 24'h0, 0, 1, 24'h0, 0);
        push("rst_w", 1, 24'h0, 0, 1, 24'h0, 0);
        ->chk_now;
        #1;
        settle();
        clr_n = 1'b1;

        set_s(1, 1, 0, 24'h0, 0, 0);
        for (int i = 1; i <= 6000; i++) begin
            tick();
            case (i)
                9:    push("up_9",    0, 24'h000009, 0, 0, 24'h0, 0);
                10:   push("up_10",   0, 24'h000010, 0, 0, 24'h0, 0);
                99:   push("up_99",   0, 24'h000099, 0, 0, 24'h0, 0);
                100:  push("up_100",  0, 24'h000100, 0, 0, 24'h0, 0);
                5999: push("up_5999", 0, 24'h005999, 0, 0, 24'h0, 0);
                6000: push("up_6000", 0, 24'h010000, 0, 0, 24'h0, 0);
                default: ;
            endcase
            settle();
        end
        set_s(0, 1, 0, 24'h0, 0, 0);
        tick(); push("ce_hold", 0, 24'h010000, 0, 0, 24'h0, 0); settle();

        set_s(0, 1, 1, 24'h595998, 0, 0);
        tick(); push("ld_sat", 0, 24'h595998, 0, 0, 24'h0, 0); settle();
        set_s(1, 1, 0, 24'h0, 0, 0);
        tick(); push("sat_hit", 0, 24'h595999, 1, 1, 24'h0, 0); settle();
        tick(); push("sat_hold1", 0, 24'h595999, 0, 1, 24'h0, 0); settle();
        tick(); push("sat_hold2", 0, 24'h595999, 0, 1, 24'h0, 0); settle();
        set_s(1, 0, 0, 24'h0, 0, 0);
        tick(); push("dir_dn", 0, 24'h595998, 0, 0, 24'h0, 0); settle();
        set_s(1, 1, 1, 24'h9F9FAF, 0, 0);
        tick(); push("clamp", 0, 24'h595999, 0, 1, 24'h0, 0); settle();
        set_s(1, 1, 1, 24'h123456, 0, 0);
        tick(); push("ld_at_lim", 0, 24'h123456, 0, 0, 24'h0, 0); settle();
        set_s(0, 0, 1, 24'h000002, 0, 0);
        tick(); push("ld_2", 0, 24'h000002, 0, 0, 24'h0, 0); settle();
        set_s(1, 0, 0, 24'h0, 0, 0);
        tick(); push("dn_1", 0, 24'h000001, 0, 0, 24'h0, 0); settle();
        tick(); push("dn_0", 0, 24'h000000, 1, 1, 24'h0, 0); settle();
        tick(); push("dn_hold", 0, 24'h000000, 0, 1, 24'h0, 0); settle();

        set_s(0, 0, 0, 24'h0, 0, 0);
        set_w(0, 0, 1, 24'h000001);
        tick(); push("w_ld", 1, 24'h000001, 0, 0, 24'h0, 0); settle();
        set_w(1, 0, 0, 24'h0);
        tick(); push("w_zero", 1, 24'h000000, 0, 1, 24'h0, 0); settle();
        tick(); push("w_roll_dn", 1, 24'h595999, 1, 0, 24'h0, 0); settle();
        tick(); push("w_dn", 1, 24'h595998, 0, 0, 24'h0, 0); settle();
        set_w(0, 1, 1, 24'h595999);
        tick(); push("w_ld_top", 1, 24'h595999, 0, 1, 24'h0, 0); settle();
        set_w(1, 1, 0, 24'h0);
        tick(); push("w_roll_up", 1, 24'h000000, 1, 0, 24'h0, 0); settle();
        tick(); push("w_up1", 1, 24'h000001, 0, 0, 24'h0, 0); settle();
        set_w(0, 0, 0, 24'h0);

        set_s(0, 1, 1, 24'h001234, 0, 0);
        tick(); push("ld_1234", 0, 24'h001234, 0, 0, 24'h0, 0); settle();
        set_s(1, 1, 0, 24'h0, 1, 0);
        tick(); push("lap_cap", 0, 24'h001235, 0, 0, lx(24'h001234), LAP); settle();
        set_s(0, 1, 0, 24'h0, 1, 1);
        tick(); push("lap_clr", 0, 24'h001235, 0, 0, 24'h0, 0); settle();
        set_s(0, 1, 1, 24'h000500, 1, 0);
        tick(); push("lap_ld", 0, 24'h000500, 0, 0, lx(24'h001235), LAP); settle();

        set_s(1, 1, 1, 24'h002999, 0, 0);
        tick(); push("ld_2999", 0, 24'h002999, 0, 0, lx(24'h001235), LAP); settle();
        set_s(1, 1, 0, 24'h0, 1, 0);
        tick(); push("to_3000", 0, 24'h003000, 0, 0, lx(24'h002999), LAP); settle();
        clr_n = 1'b0;
        #1;
        push("rst_mid_s", 0, 24'h0, 0, 0, 24'h0, 0);
        push("rst_mid_w", 1, 24'h0, 0, 1, 24'h0, 0);
        ->chk_now;
        #1;
        set_s(1, 1, 0, 24'h0, 0, 0);
        settle();
        clr_n = 1'b1;
        tick(); push("resume1", 0, 24'h000001, 0, 0, 24'h0, 0); settle();
        tick(); push("resume2", 0, 24'h000002, 0, 0, 24'h0, 0); settle();

        set_s(0, 1, 0, 24'h0, 0, 0);
        settle();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_cnt.md
# bcd_stopwatch_cnt

Six-digit BCD stopwatch/timer counter (MM:SS.hh) clocked at 100 Hz. It is the parametrised successor to the fixed up-only stopwatch counter and adds:
- run-time up/down direction (countdown timer mode)
- preset load
- selectable saturate or wrap at the terminal value
- a one-cycle terminal pulse
- optional lap capture

It sits between the 100 Hz clock divider and the display/BCD-to-7-segment mux.

## Interface
Parameters:
- MIN_MSB_MAX, default 5: maximum of the minutes-tens digit (legal 1..9); terminal value is {MIN_MSB_MAX,9}:59.99.
- WRAP, default 0: 0 = saturate at terminal value; 1 = roll over.

Ports:
- clk_100hz  in  1  counter clock; all state updates on its rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- ce  in  1  count enable, high active.
- up  in  1  direction: 1 = count up, 0 = count down.
- load  in  1  synchronous preset strobe.
- load_val  in  24  preset, packed BCD {min_msb,min_lsb,sec_msb,sec_lsb,lit_msb,lit_lsb}, 4 bits each.
- lap  in  1  lap capture strobe (used only with lap capture compiled in).
- lap_clr  in  1  clears the lap register (used only with lap capture compiled in).
- time_bcd  out  24  current count, same packing as load_val.
- lap_bcd  out  24  captured lap value.
- lap_valid  out  1  lap_bcd holds a capture.
- at_limit  out  1  combinational: count equals the limit for the current direction.
- done  out  1  registered one-cycle terminal pulse.

## Operation
Digit ranges:
- lit_lsb, lit_msb, sec_lsb, min_lsb: 0..9
- sec_msb: 0..5
- min_msb: 0..MIN_MSB_MAX

Limits:
- Limit for up is the terminal value.
- Limit for down is 00:00.00.

Priority on each edge, highest first: load, then count.
- Load: time_bcd <= load_val. Any digit above its maximum is clamped to that maximum. done is not asserted by a load.
- Count when ce=1:
  - Up: lsb digit increments. A digit wraps to 0 and carries when it and all lower digits are at their maximum.
  - Down: lsb digit decrements. A digit wraps to its maximum and borrows when it and all lower digits are 0.
  - If at_limit=1 and WRAP=0: count holds; no change.
  - If at_limit=1 and WRAP=1: up goes to 00:00.00; down goes to the terminal value.
- When ce=0 the count holds.
- up is sampled every edge; a direction change takes effect on the very next counting edge.

done is high for exactly one cycle after a counting edge that:
- WRAP=0: moved the count onto the limit.
- WRAP=1: performed a rollover.

done is never asserted by load or reset.

## Timing
- Reset (clr_n=0, asynchronous) clears:
  - time_bcd=0
  - lap_bcd=0
  - lap_valid=0
  - done=0
- Release of clr_n is synchronous to clk_100hz; the first count occurs on the first rising edge with clr_n=1 and ce=1.
- Latency:
  - time_bcd changes 1 edge after ce/load is sampled.
  - done coincides with the cycle in which time_bcd first shows the limit (WRAP=0) or the rollover value (WRAP=1).
- at_limit tracks time_bcd and up combinationally, with no added latency.
- Simultaneous events:
  - load with ce: load wins.
  - load while at the limit: load wins; done stays 0.
  - lap with load/count: captures the pre-edge time_bcd.
  - lap_clr with lap: lap_clr wins.
- clr_n asserted mid-count aborts immediately; no done pulse is produced.

## Configuration
- Macro BCD_STOPWATCH_LAP_EN:
  - Defined: lap capture is compiled in. On an edge with lap=1 and lap_clr=0: lap_bcd <= time_bcd (pre-edge value) and lap_valid <= 1. A later lap overwrites the capture. lap_clr=1 sets lap_bcd=0 and lap_valid=0.
  - Undefined: no lap register; lap_bcd is tied to 0 and lap_valid to 0; lap and lap_clr are ignored.

## Test plan
- Reset, then ce=1 and up=1 for 6000 edges -> time_bcd = 01:00.00 (0x010000). Carries are checked at 00:00.09->00:00.10, 00:00.99->00:01.00 and 00:59.99->01:00.00.
- WRAP=0, load 59:59.98, up=1, ce=1, 3 edges -> time_bcd 59:59.99 after edge 1, then holds; done high for exactly 1 cycle; at_limit=1.
- WRAP=1, up=0, load 00:00.01, 2 edges -> 00:00.00 then 59:59.99; done pulses only on the rollover edge.
- Load 9F:9F.AF with MIN_MSB_MAX=5 -> time_bcd = 59:59.99 (clamped); done=0. Load and ce asserted together -> the load value wins.
- With BCD_STOPWATCH_LAP_EN: at count 00:12.34 assert lap and ce -> lap_bcd=0x001234, lap_valid=1, time_bcd=00:12.35. Then assert lap and lap_clr together -> lap_valid=0, lap_bcd=0.
- Assert clr_n low mid-count at 00:30.00 with no clock edge -> all outputs 0 immediately. Release -> counting resumes from 00:00.00 with no done pulse.
